// File: rtl/write_word.sv
// Read-modify-write of one byte-masked word inside a DRAM row.
// Fetches the row, merges the word into it, then stores the row back.
module write_word #(
    parameter int TGT_BITS      = 64,
    parameter int WORDS_PER_ROW = 32,
    parameter int ROW_BITS      = TGT_BITS*WORDS_PER_ROW,
    parameter int ADR_BITS      = 5,
    parameter int ROWADR_BITS   = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   writeGo,
    input  logic [ADR_BITS-1:0]    address,
    input  logic [ROWADR_BITS-1:0] rowAdr,
    input  logic [TGT_BITS-1:0]    wordIn,
    input  logic [TGT_BITS/8-1:0]  byteEn,
    output logic                   busy,
    output logic                   writeDone,
    output logic                   overrun,
    output logic                   rowRdReq,
    input  logic                   rowRdAck,
    input  logic [ROW_BITS-1:0]    dramI,
    output logic                   rowWrReq,
    input  logic                   rowWrAck,
    output logic [ROWADR_BITS-1:0] rowAdrO,
    output logic [ROW_BITS-1:0]    dramO
);

    localparam int BE_BITS = TGT_BITS/8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        MERGE,
        STORE
    } state_t;

    state_t                 state;
    logic [ADR_BITS-1:0]    adr_q;
    logic [ROWADR_BITS-1:0] row_q;
    logic [TGT_BITS-1:0]    word_q;
    logic [BE_BITS-1:0]     be_q;
    logic [ROW_BITS-1:0]    row_buf;
    logic [ROW_BITS-1:0]    merged;

    assign rowAdrO = row_q;
    assign dramO   = row_buf;

    // Slots at or beyond WORDS_PER_ROW match no word, so the row passes through.
    always_comb begin
        merged = row_buf;
        for (int w = 0; w < WORDS_PER_ROW; w++) begin
            for (int b = 0; b < BE_BITS; b++) begin
                if (int'(adr_q) == w && be_q[b]) begin
                    merged[w*TGT_BITS + b*8 +: 8] = word_q[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            writeDone <= 1'b0;
            overrun   <= 1'b0;
            rowRdReq  <= 1'b0;
            rowWrReq  <= 1'b0;
            adr_q     <= '0;
            row_q     <= '0;
            word_q    <= '0;
            be_q      <= '0;
            row_buf   <= '0;
        end else begin
            writeDone <= 1'b0;
            overrun   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (writeGo) begin
                        if (byteEn != '0) begin
                            adr_q    <= address;
                            row_q    <= rowAdr;
                            word_q   <= wordIn;
                            be_q     <= byteEn;
                            state    <= FETCH;
                            busy     <= 1'b1;
                            rowRdReq <= 1'b1;
                        end else begin
                            writeDone <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    overrun <= writeGo;
                    if (rowRdAck) begin
                        row_buf  <= dramI;
                        rowRdReq <= 1'b0;
                        state    <= MERGE;
                    end
                end
                MERGE: begin
                    overrun  <= writeGo;
                    row_buf  <= merged;
                    rowWrReq <= 1'b1;
                    state    <= STORE;
                end
                STORE: begin
                    overrun <= writeGo;
                    if (rowWrAck) begin
                        rowWrReq  <= 1'b0;
                        busy      <= 1'b0;
                        writeDone <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rowRdReq <= 1'b0;
                    rowWrReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_word.sv
// Directed bench for write_word: timing, merge data, overrun,
// back-to-back, empty byte mask and mid-store reset.
module tb_write_word;

    logic          clk = 1'b0;
    logic          reset;
    logic          writeGo;
    logic [4:0]    address;
    logic [9:0]    rowAdr;
    logic [63:0]   wordIn;
    logic [7:0]    byteEn;
    logic          busy;
    logic          writeDone;
    logic          overrun;
    logic          rowRdReq;
    logic          rowRdAck;
    logic [2047:0] dramI;
    logic          rowWrReq;
    logic          rowWrAck;
    logic [9:0]    rowAdrO;
    logic [2047:0] dramO;

    int checks = 0;
    int errors = 0;

    write_word dut (
        .clk(clk), .reset(reset), .writeGo(writeGo),
        .address(address), .rowAdr(rowAdr), .wordIn(wordIn),
        .byteEn(byteEn), .busy(busy), .writeDone(writeDone),
        .overrun(overrun), .rowRdReq(rowRdReq), .rowRdAck(rowRdAck),
        .dramI(dramI), .rowWrReq(rowWrReq), .rowWrAck(rowWrAck),
        .rowAdrO(rowAdrO), .dramO(dramO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_adr(input string tag, input logic [9:0] obs,
                           input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [2047:0] obs,
                           input logic [2047:0] exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int i = 31; i >= 0; i--)
                if (obs[i*64 +: 64] !== exp[i*64 +: 64]) bad = i;
            $error("FAIL %s word %0d obs=%h exp=%h", tag, bad,
                   obs[bad*64 +: 64], exp[bad*64 +: 64]);
        end
    endtask

    // Runs one request; acks are returned after rd_dly / wr_dly wait cycles.
    // go_cyc > 0 injects a stray writeGo with different fields in that cycle.
    task automatic do_write(input logic [4:0] a, input logic [9:0] r,
                            input logic [63:0] w, input logic [7:0] be,
                            input logic [2047:0] din,
                            input logic [2047:0] exp,
                            input int rd_dly, input int wr_dly,
                            input int go_cyc,
                            output int lat, output int ovr);
        int rc;
        int wc;
        address = a;
        rowAdr  = r;
        wordIn  = w;
        byteEn  = be;
        dramI   = din;
        writeGo = 1'b1;
        tick();
        writeGo = 1'b0;
        chk1("req_first", rowRdReq, 1'b1);
        lat = 1;
        ovr = 0;
        rc  = 0;
        wc  = 0;
        while (!writeDone && lat < 60) begin
            if (overrun) ovr++;
            chk1("busy", busy, 1'b1);
            chk1("excl", rowRdReq & rowWrReq, 1'b0);
            if (rowRdReq) begin
                chk_adr("rowadr_rd", rowAdrO, r);
                rowRdAck = (rc == rd_dly);
                rc++;
            end else begin
                rowRdAck = 1'b0;
            end
            if (rowWrReq) begin
                chk_adr("rowadr_wr", rowAdrO, r);
                chk_row("dram_store", dramO, exp);
                rowWrAck = (wc == wr_dly);
                wc++;
            end else begin
                rowWrAck = 1'b0;
            end
            writeGo = (lat == go_cyc);
            if (writeGo) begin
                address = ~a;
                rowAdr  = ~r;
                wordIn  = ~w;
                byteEn  = 8'hFF;
            end
            tick();
            lat++;
        end
        rowRdAck = 1'b0;
        rowWrAck = 1'b0;
        writeGo  = 1'b0;
        chk1("done_seen", writeDone, 1'b1);
        chk1("idle_busy", busy, 1'b0);
        chk_int("rd_cycles", rc, rd_dly + 1);
        chk_int("wr_cycles", wc, wr_dly + 1);
        chk_row("dram_final", dramO, exp);
    endtask

    initial begin
        logic [2047:0] exp;
        logic [2047:0] din;
        int lat;
        int ovr;

        reset    = 1'b1;
        writeGo  = 1'b0;
        address  = '0;
        rowAdr   = '0;
        wordIn   = '0;
        byteEn   = '0;
        rowRdAck = 1'b0;
        rowWrAck = 1'b0;
        dramI    = '0;
        tick();
        tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", writeDone, 1'b0);
        chk1("rst_ovr", overrun, 1'b0);
        chk1("rst_rdreq", rowRdReq, 1'b0);
        chk1("rst_wrreq", rowWrReq, 1'b0);
        chk_adr("rst_rowadr", rowAdrO, 10'h000);
        chk_row("rst_dram", dramO, '0);
        reset = 1'b0;
        tick();

        // Full word into slot 5 of an all-ones row
        din = '1;
        exp = '1;
        exp[383:320] = 64'h0123456789ABCDEF;
        do_write(5'd5, 10'h155, 64'h0123456789ABCDEF, 8'hFF, din, exp,
                 0, 0, 0, lat, ovr);
        chk_int("basic_lat", lat, 4);
        chk_int("basic_ovr", ovr, 0);
        tick();

        // Low four bytes into top slot of a zero row
        din = '0;
        exp = '0;
        exp[2015:1984] = 32'h89ABCDEF;
        do_write(5'd31, 10'h2AA, 64'h0123456789ABCDEF, 8'h0F, din, exp,
                 0, 0, 0, lat, ovr);
        chk_int("part_lat", lat, 4);
        tick();

        // Slow acknowledges
        din = {32{64'hA5A5A5A5A5A5A5A5}};
        exp = din;
        exp[63:0] = 64'h0F1E2D3C4B5A6978;
        do_write(5'd0, 10'h3FF, 64'h0F1E2D3C4B5A6978, 8'hFF, din, exp,
                 3, 2, 0, lat, ovr);
        chk_int("slow_lat", lat, 9);
        tick();

        // Stray writeGo during FETCH
        din = '0;
        exp = '0;
        exp[511:448] = 64'hDEADBEEFCAFEF00D;
        do_write(5'd7, 10'h0C3, 64'hDEADBEEFCAFEF00D, 8'hFF, din, exp,
                 1, 0, 1, lat, ovr);
        chk_int("ovr_count", ovr, 1);
        chk_int("ovr_lat", lat, 5);

        // Back-to-back: issued in the writeDone cycle
        chk1("b2b_done", writeDone, 1'b1);
        din = '1;
        exp = '1;
        exp[191:128] = 64'h11FFFFFFFFFFFF88;
        do_write(5'd2, 10'h011, 64'h1122334455667788, 8'h81, din, exp,
                 0, 0, 0, lat, ovr);
        chk_int("b2b_lat", lat, 4);
        chk_int("b2b_ovr", ovr, 0);

        // Empty byte mask
        address = 5'd9;
        byteEn  = 8'h00;
        writeGo = 1'b1;
        dramI   = '0;
        tick();
        writeGo = 1'b0;
        chk1("be0_done", writeDone, 1'b1);
        chk1("be0_rdreq", rowRdReq, 1'b0);
        chk1("be0_busy", busy, 1'b0);
        tick();
        chk1("be0_done2", writeDone, 1'b0);
        chk1("be0_rdreq2", rowRdReq, 1'b0);
        chk1("be0_wrreq2", rowWrReq, 1'b0);
        chk_row("be0_dram", dramO, exp);

        // Reset while in STORE
        address = 5'd1;
        rowAdr  = 10'h123;
        wordIn  = 64'h5555AAAA5555AAAA;
        byteEn  = 8'hFF;
        dramI   = '0;
        writeGo = 1'b1;
        tick();
        writeGo  = 1'b0;
        rowRdAck = 1'b1;
        tick();
        rowRdAck = 1'b0;
        tick();
        chk1("rs_wrreq_pre", rowWrReq, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rs_wrreq", rowWrReq, 1'b0);
        chk1("rs_busy", busy, 1'b0);
        chk_adr("rs_rowadr", rowAdrO, 10'h000);
        chk_row("rs_dram", dramO, '0);
        #2;
        reset    = 1'b0;
        rowWrAck = 1'b1;
        rowRdAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("rs_nodone", writeDone, 1'b0);
            chk1("rs_nowr", rowWrReq, 1'b0);
            chk1("rs_nobusy", busy, 1'b0);
        end
        rowWrAck = 1'b0;
        rowRdAck = 1'b0;
        chk_row("rs_dram_after", dramO, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
